// File: rtl/full_adder_pkg.sv
// Shared constants and the carry helper for the registered ripple-carry adder.
// Optional signed-overflow output is enabled with FULL_ADDER_OVF_EN.
package full_adder_pkg;

  localparam int FA_MAX_WIDTH = 64;
  localparam logic [FA_MAX_WIDTH-1:0] FA_RESET_SUM = '0;

  // Majority of three inputs: the carry-out of a single full-adder cell.
  function automatic logic fa_majority(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/full_adder_if.sv
// Operand/result bundle for full_adder; the ovf flag exists only when
// FULL_ADDER_OVF_EN is defined.
interface full_adder_if #(
  parameter int WIDTH = 1
);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             in_valid;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             out_valid;

`ifdef FULL_ADDER_OVF_EN
  logic             ovf;

  modport master (output A, B, Cin, in_valid, input S, Cout, out_valid, ovf);
  modport slave  (input A, B, Cin, in_valid, output S, Cout, out_valid, ovf);
`else
  modport master (output A, B, Cin, in_valid, input S, Cout, out_valid);
  modport slave  (input A, B, Cin, in_valid, output S, Cout, out_valid);
`endif

endinterface

// File: rtl/fa_bit.sv
// Combinational 1-bit full-adder cell: one link of the ripple-carry chain.
module fa_bit
  import full_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = fa_majority(a, b, cin);

endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder, latency one cycle.
// Defining FULL_ADDER_OVF_EN adds a registered signed-overflow flag (ovf).
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  full_adder_if.slave  bus
);

  if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_bad_width
    $error("full_adder: WIDTH out of range");
  end

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;

  assign carry[0] = bus.Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa_bit u_bit (
      .a    (bus.A[i]),
      .b    (bus.B[i]),
      .cin  (carry[i]),
      .s    (sum_c[i]),
      .cout (carry[i+1])
    );
  end

  // Result register: reset wins, a valid input loads, otherwise sum/carry hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.S         <= FA_RESET_SUM[WIDTH-1:0];
      bus.Cout      <= 1'b0;
      bus.out_valid <= 1'b0;
    end else if (bus.in_valid) begin
      bus.S         <= sum_c;
      bus.Cout      <= carry[WIDTH];
      bus.out_valid <= 1'b1;
    end else begin
      bus.S         <= bus.S;
      bus.Cout      <= bus.Cout;
      bus.out_valid <= 1'b0;
    end
  end

`ifdef FULL_ADDER_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ovf <= 1'b0;
    end else if (bus.in_valid) begin
      bus.ovf <= carry[WIDTH] ^ carry[WIDTH-1];
    end else begin
      bus.ovf <= bus.ovf;
    end
  end
`endif

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder at WIDTH=1 and WIDTH=8 (honours FULL_ADDER_OVF_EN).
module tb_full_adder;

  typedef struct {
    logic       v;
    logic [7:0] s;
    logic       c;
    logic       o;
  } exp_t;

  logic clk;
  logic rst;

  full_adder_if #(.WIDTH(1)) if1 ();
  full_adder_if #(.WIDTH(8)) if8 ();

  full_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  full_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t q1[$];
  exp_t q8[$];
  int   checks = 0;
  int   errors = 0;

  // stimulus settings for the next cycle
  logic       r_i;
  logic       v1_i, a1_i, b1_i, c1_i;
  logic       v8_i, c8_i;
  logic [7:0] a8_i, b8_i;
  logic       hand1, hs1, hc1;
  logic       hand8, hc8, ho8;
  logic [7:0] hs8;

  // reference model state
  logic       m1_s, m1_c, m1_o;
  logic [7:0] m8_s;
  logic       m8_c, m8_o;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    exp_t       e1, e8;
    logic [7:0] low;
    logic [1:0] s1w;
    if1.A = a1_i; if1.B = b1_i; if1.Cin = c1_i; if1.in_valid = v1_i;
    if8.A = a8_i; if8.B = b8_i; if8.Cin = c8_i; if8.in_valid = v8_i;
    rst = r_i;
    if (r_i) begin
      {m1_s, m1_c, m1_o} = 3'b000;
    end else if (v1_i) begin
      if (hand1) begin
        m1_s = hs1; m1_c = hc1;
      end else begin
        s1w = {1'b0, a1_i} + {1'b0, b1_i} + {1'b0, c1_i};
        {m1_c, m1_s} = s1w;
      end
      m1_o = m1_c ^ c1_i;
    end
    e1.v = !r_i && v1_i; e1.s = {7'b0, m1_s}; e1.c = m1_c; e1.o = m1_o;
    if (r_i) begin
      m8_s = 8'h00; m8_c = 1'b0; m8_o = 1'b0;
    end else if (v8_i) begin
      if (hand8) begin
        m8_s = hs8; m8_c = hc8; m8_o = ho8;
      end else begin
        {m8_c, m8_s} = {1'b0, a8_i} + {1'b0, b8_i} + {8'b0, c8_i};
        low  = {1'b0, a8_i[6:0]} + {1'b0, b8_i[6:0]} + {7'b0, c8_i};
        m8_o = m8_c ^ low[7];
      end
    end
    e8.v = !r_i && v8_i; e8.s = m8_s; e8.c = m8_c; e8.o = m8_o;
    q1.push_back(e1);
    q8.push_back(e8);
    @(posedge clk);
    #1;
    hand1 = 1'b0;
    hand8 = 1'b0;
  endtask

  // Monitor: each falling edge compares the result registered at the preceding rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("w1_out_valid", {63'b0, if1.out_valid}, {63'b0, e.v});
      chk("w1_S", {63'b0, if1.S}, {56'b0, e.s});
      chk("w1_Cout", {63'b0, if1.Cout}, {63'b0, e.c});
`ifdef FULL_ADDER_OVF_EN
      chk("w1_ovf", {63'b0, if1.ovf}, {63'b0, e.o});
`endif
    end
    if (q8.size() > 0) begin
      e = q8.pop_front();
      chk("w8_out_valid", {63'b0, if8.out_valid}, {63'b0, e.v});
      chk("w8_S", {56'b0, if8.S}, {56'b0, e.s});
      chk("w8_Cout", {63'b0, if8.Cout}, {63'b0, e.c});
`ifdef FULL_ADDER_OVF_EN
      chk("w8_ovf", {63'b0, if8.ovf}, {63'b0, e.o});
`endif
    end
  end

  task automatic w8_hand(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic [7:0] s, input logic co, input logic o);
    v8_i = 1'b1; a8_i = a; b8_i = b; c8_i = c;
    hand8 = 1'b1; hs8 = s; hc8 = co; ho8 = o;
    tick();
  endtask

  initial begin
    logic [7:0] tt_s;
    logic [7:0] tt_c;
    logic [2:0] abc;
    tt_s = 8'b1001_0110;
    tt_c = 8'b1110_1000;
    hand1 = 1'b0; hs1 = 1'b0; hc1 = 1'b0;
    hand8 = 1'b0; hs8 = 8'h00; hc8 = 1'b0; ho8 = 1'b0;
    m1_s = 1'b0; m1_c = 1'b0; m1_o = 1'b0;
    m8_s = 8'h00; m8_c = 1'b0; m8_o = 1'b0;
    r_i = 1'b1; v1_i = 1'b0; a1_i = 1'b0; b1_i = 1'b0; c1_i = 1'b0;
    v8_i = 1'b0; a8_i = 8'h00; b8_i = 8'h00; c8_i = 1'b0;
    tick();
    tick();

    // reset held for two cycles with a valid all-ones input pending
    v1_i = 1'b1; a1_i = 1'b1; b1_i = 1'b1; c1_i = 1'b1;
    tick();
    tick();
    r_i = 1'b0;
    hand1 = 1'b1; hs1 = 1'b1; hc1 = 1'b1;
    tick();

    // WIDTH=1 exhaustive truth table, bit order {A,B,Cin}
    for (int i = 0; i < 8; i++) begin
      abc = i[2:0];
      v1_i = 1'b1; a1_i = abc[2]; b1_i = abc[1]; c1_i = abc[0];
      hand1 = 1'b1; hs1 = tt_s[i]; hc1 = tt_c[i];
      tick();
    end

    // hold: 1+1+0 then three idle cycles with changing inputs
    v1_i = 1'b1; a1_i = 1'b1; b1_i = 1'b1; c1_i = 1'b0;
    hand1 = 1'b1; hs1 = 1'b0; hc1 = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      v1_i = 1'b0; a1_i = ~a1_i; b1_i = i[0]; c1_i = ~c1_i;
      tick();
    end

    // reset mid-stream drops the in-flight result
    v1_i = 1'b1; a1_i = 1'b1; b1_i = 1'b0; c1_i = 1'b1;
    tick();
    r_i = 1'b1;
    tick();
    r_i = 1'b0; v1_i = 1'b0;
    tick();

    // WIDTH=8 boundaries and overflow cases
    w8_hand(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    w8_hand(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    w8_hand(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    w8_hand(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    w8_hand(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    w8_hand(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
    v8_i = 1'b0; a8_i = 8'hA5; b8_i = 8'h3C;
    tick();

    // WIDTH=8 back-to-back random traffic against the arithmetic model
    for (int i = 0; i < 1000; i++) begin
      v8_i = 1'b1;
      a8_i = 8'($urandom_range(0, 255));
      b8_i = 8'($urandom_range(0, 255));
      c8_i = 1'($urandom_range(0, 1));
      tick();
    end
    v8_i = 1'b0;
    tick();

    @(negedge clk);
    #1;
    chk("q1_drained", 64'(q1.size()), 64'd0);
    chk("q8_drained", 64'(q8.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
